// File: rtl/gray_line_window.sv
// gray_line_window: vertical window generator for a gray AXI4-Stream.
// Keeps WIN_H-1 previous lines in line memories and, for every accepted beat
// of the current line, emits the same PPC columns from WIN_H lines stacked
// (slice k = line y-k, k=0 at the LSBs).
// Optional feature macro: LINE_LEN_CHECK_EN adds the sticky line_err output,
// flagging lines whose beat count differs from line 0 of the frame.
// dbg_state_o exposes the FSM state (0=IDLE, 1=PRIME, 2=STREAM).
//
// Handshake: a beat moves on a channel when tvalid & tready are both high at
// a rising edge. A raised tvalid is held with stable payload until taken.
// The output is a single register stage, so the input is ready whenever that
// register is empty or is being drained in the same cycle.
module gray_line_window #(
  parameter int DATA_WIDTH = 8,
  parameter int PPC        = 4,
  parameter int WIN_H      = 3,
  parameter int MAX_WIDTH  = 1920
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [DATA_WIDTH*PPC-1:0]        s_axis_gray_tdata,
  input  logic                             s_axis_gray_tvalid,
  output logic                             s_axis_gray_tready,
  input  logic                             s_axis_gray_tuser,
  input  logic                             s_axis_gray_tlast,
  output logic [DATA_WIDTH*PPC*WIN_H-1:0]  m_axis_win_tdata,
  output logic                             m_axis_win_tvalid,
  input  logic                             m_axis_win_tready,
  output logic                             m_axis_win_tuser,
  output logic                             m_axis_win_tlast,
`ifdef LINE_LEN_CHECK_EN
  output logic                             line_err,
`endif
  output logic [1:0]                       dbg_state_o
);

  localparam int BW    = DATA_WIDTH * PPC;
  localparam int OW    = BW * WIN_H;
  localparam int DEPTH = MAX_WIDTH / PPC;
  localparam int COL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LC_W  = $clog2(WIN_H);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(DEPTH - 1);
  localparam logic [LC_W-1:0]  LAST_LINE = LC_W'(WIN_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LC_W-1:0]   line_cnt_q, line_cnt_d;
  logic              first_q, first_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic [OW-1:0]     m_tdata_q, m_tdata_d;
  logic              m_tuser_q, m_tuser_d;
  logic              m_tlast_q, m_tlast_d;

  logic              accept;
  logic              wr_en;
  logic              emit;
  logic [COL_W-1:0]  wr_col;
  logic [COL_W-1:0]  col_base;
  logic [LC_W-1:0]   line_base;
  logic [OW-1:0]     win_data;

  // Line memories; contents survive reset on purpose.
  logic [BW-1:0]     mem_q [WIN_H-1][DEPTH];

  assign s_axis_gray_tready = !m_tvalid_q || m_axis_win_tready;
  assign accept = s_axis_gray_tvalid && s_axis_gray_tready;
  // A tuser beat always restarts the frame, even from IDLE.
  assign wr_en  = accept && (s_axis_gray_tuser || (state_q != ST_IDLE));
  assign emit   = accept && !s_axis_gray_tuser && (state_q == ST_STREAM);
  assign wr_col = s_axis_gray_tuser ? '0 : col_q;

  assign m_axis_win_tdata  = m_tdata_q;
  assign m_axis_win_tvalid = m_tvalid_q;
  assign m_axis_win_tuser  = m_tuser_q;
  assign m_axis_win_tlast  = m_tlast_q;
  assign dbg_state_o       = state_q;

  // Window column: current beat at the LSBs, older lines above (read-before-write).
  always_comb begin
    win_data = '0;
    win_data[BW-1:0] = s_axis_gray_tdata;
    for (int k = 1; k < WIN_H; k++) begin
      win_data[k*BW +: BW] = mem_q[k-1][col_q];
    end
  end

  // Line memory shift: new beat into line 0, each older line moves up one slot.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[0][wr_col] <= s_axis_gray_tdata;
      for (int k = 1; k < WIN_H - 1; k++) begin
        mem_q[k][wr_col] <= mem_q[k-1][wr_col];
      end
    end
  end

  // Next-state logic for the FSM, column/line counters and output register.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_cnt_d = line_cnt_q;
    first_d    = first_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    col_base   = s_axis_gray_tuser ? '0 : col_q;
    line_base  = s_axis_gray_tuser ? '0 : line_cnt_q;

    if (m_axis_win_tready) begin
      m_tvalid_d = 1'b0;
    end

    if (wr_en) begin
      if (s_axis_gray_tlast) begin
        col_d      = '0;
        line_cnt_d = (line_base == LAST_LINE) ? line_base : line_base + 1'b1;
      end else begin
        // Overlong lines park on the last word and overwrite it.
        col_d      = (col_base == COL_MAX) ? col_base : col_base + 1'b1;
        line_cnt_d = line_base;
      end
      state_d = (line_cnt_d == LAST_LINE) ? ST_STREAM : ST_PRIME;
      if ((state_d == ST_STREAM) && ((state_q != ST_STREAM) || s_axis_gray_tuser)) begin
        first_d = 1'b1;
      end else if (state_d == ST_PRIME) begin
        first_d = 1'b0;
      end
    end

    if (emit) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = win_data;
      m_tuser_d  = first_q;
      m_tlast_d  = s_axis_gray_tlast;
      first_d    = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      line_cnt_q <= '0;
      first_q    <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_cnt_q <= line_cnt_d;
      first_q    <= first_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

`ifdef LINE_LEN_CHECK_EN
  localparam int LEN_W = COL_W + 2;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic [LEN_W-1:0] ref_len_q, ref_len_d;
  logic             ref_vld_q, ref_vld_d;
  logic             line_err_q, line_err_d;
  logic [LEN_W-1:0] len_base;
  logic [LEN_W-1:0] beats;
  logic             ref_vld_eff;

  assign line_err = line_err_q;

  // Line-length check: line 0 sets the reference, later lines compare at tlast.
  always_comb begin
    len_cnt_d   = len_cnt_q;
    ref_len_d   = ref_len_q;
    ref_vld_d   = ref_vld_q;
    line_err_d  = line_err_q;
    len_base    = s_axis_gray_tuser ? '0 : len_cnt_q;
    beats       = (len_base == LEN_MAX) ? len_base : len_base + 1'b1;
    ref_vld_eff = s_axis_gray_tuser ? 1'b0 : ref_vld_q;
    if (wr_en) begin
      if (s_axis_gray_tuser) begin
        line_err_d = 1'b0;
        ref_vld_d  = 1'b0;
      end
      if (s_axis_gray_tlast) begin
        len_cnt_d = '0;
        if (!ref_vld_eff) begin
          ref_len_d = beats;
          ref_vld_d = 1'b1;
        end else if (beats != ref_len_q) begin
          line_err_d = 1'b1;
        end
      end else begin
        len_cnt_d = beats;
      end
    end
  end

  // Line-length check registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      len_cnt_q  <= '0;
      ref_len_q  <= '0;
      ref_vld_q  <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      len_cnt_q  <= len_cnt_d;
      ref_len_q  <= ref_len_d;
      ref_vld_q  <= ref_vld_d;
      line_err_q <= line_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_gray_line_window.sv
// tb_gray_line_window: directed bench for gray_line_window with
// DATA_WIDTH=8, PPC=4, WIN_H=3, MAX_WIDTH=16 (4 beats per line).
// Beat (line L, beat B) carries {4{8'(L*16+B)}}.
module tb_gray_line_window;

  localparam int DW = 8;
  localparam int PP = 4;
  localparam int WH = 3;
  localparam int MW = 16;
  localparam int BW = DW * PP;
  localparam int OW = BW * WH;

  logic          aclk;
  logic          aresetn;
  logic [BW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tuser;
  logic          s_tlast;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tuser;
  logic          m_tlast;
  logic [1:0]    dbg_state;
`ifdef LINE_LEN_CHECK_EN
  logic          line_err;
`endif

  int checks = 0;
  int errors = 0;
  int recv_cnt = 0;
  int exp_total = 0;
  logic [OW+1:0] exp_q[$];

  gray_line_window #(
    .DATA_WIDTH(DW), .PPC(PP), .WIN_H(WH), .MAX_WIDTH(MW)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_gray_tdata  (s_tdata),
    .s_axis_gray_tvalid (s_tvalid),
    .s_axis_gray_tready (s_tready),
    .s_axis_gray_tuser  (s_tuser),
    .s_axis_gray_tlast  (s_tlast),
    .m_axis_win_tdata   (m_tdata),
    .m_axis_win_tvalid  (m_tvalid),
    .m_axis_win_tready  (m_tready),
    .m_axis_win_tuser   (m_tuser),
    .m_axis_win_tlast   (m_tlast),
`ifdef LINE_LEN_CHECK_EN
    .line_err           (line_err),
`endif
    .dbg_state_o        (dbg_state)
  );

  // Clock and watchdog
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] px(input int l, input int b);
    logic [DW-1:0] v;
    v = DW'(l * 16 + b);
    return {PP{v}};
  endfunction

  // Expected output beat for line l (l>=2), beat b: {tuser, tlast, window}
  function automatic logic [OW+1:0] win_exp(input int l, input int b, input logic u, input logic t);
    return {u, t, px(l - 2, b), px(l - 1, b), px(l, b)};
  endfunction

  task automatic exp_line(input int l, input int nb, input logic first);
    for (int b = 0; b < nb; b++) begin
      exp_q.push_back(win_exp(l, b, first && (b == 0), b == nb - 1));
      exp_total++;
    end
  endtask

  // Driver: present one beat, wait (bounded) for acceptance.
  task automatic send(input logic [BW-1:0] d, input logic u, input logic l);
    int n;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge aclk);
    end
    if (!s_tready) chk("s_accept_timeout", 128'(s_tready), 128'd1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_line(input int l, input int nb, input logic u);
    for (int b = 0; b < nb; b++) begin
      send(px(l, b), u && (b == 0), b == nb - 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      n++;
      @(posedge aclk);
    end
    @(posedge aclk);
    #1;
    chk("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // Scoreboard: every handshaken output beat is compared in order.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat_exp_q_size", 128'(exp_q.size()), 128'd1);
      end else begin
        chk("out_beat", 128'({m_tuser, m_tlast, m_tdata}), 128'(exp_q.pop_front()));
      end
      recv_cnt++;
    end
  end

  initial begin
    logic [OW-1:0] hold;
    int n;
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
    chk("rst_m_tdata",  128'(m_tdata),  128'd0);
    chk("rst_m_tuser",  128'(m_tuser),  128'd0);
    chk("rst_m_tlast",  128'(m_tlast),  128'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("rst_s_tready", 128'(s_tready), 128'd1);
    chk("rst_state",    128'(dbg_state), 128'd0);

    // Beats before the first tuser are dropped, then a clean 4-line frame
    for (int b = 0; b < 4; b++) send(32'hEEEEEEEE, 1'b0, b == 3);
    chk("idle_state", 128'(dbg_state), 128'd0);
    exp_line(2, 4, 1'b1);
    exp_line(3, 4, 1'b0);
    for (int l = 0; l < 4; l++) send_line(l, 4, l == 0);
    drain();
    chk("frame1_count", 128'(recv_cnt), 128'd8);

    // Backpressure: output held stable, input stalled
    exp_line(2, 4, 1'b1);
    exp_line(3, 4, 1'b0);
    m_tready = 1'b0;
    fork
      begin
        for (int l = 0; l < 4; l++) send_line(l, 4, l == 0);
      end
      begin
        n = 0;
        @(negedge aclk);
        while (!m_tvalid && n < 200) begin
          n++;
          @(negedge aclk);
        end
        hold = m_tdata;
        chk("bp_tdata_first", 128'(hold), 128'(win_exp(2, 0, 1'b0, 1'b0)));
        repeat (3) begin
          @(negedge aclk);
          chk("bp_s_tready", 128'(s_tready), 128'd0);
          chk("bp_m_tvalid", 128'(m_tvalid), 128'd1);
          chk("bp_m_tdata",  128'(m_tdata),  128'(hold));
        end
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();
    chk("frame2_count", 128'(recv_cnt), 128'd16);

    // tuser at line 3 beat 0 re-primes: lines 3,4 silent, line 5 emits with tuser
    exp_line(2, 4, 1'b1);
    for (int l = 0; l < 3; l++) send_line(l, 4, l == 0);
    send_line(3, 4, 1'b1);
    send_line(4, 4, 1'b0);
    exp_line(5, 4, 1'b1);
    send_line(5, 4, 1'b0);
    drain();
    chk("reprime_count", 128'(recv_cnt), 128'(exp_total));

    // One-beat lines: tuser&tlast is a complete line 0
    exp_q.push_back(win_exp(10, 0, 1'b1, 1'b1));
    exp_total++;
    send(px(8, 0), 1'b1, 1'b1);
    send(px(9, 0), 1'b0, 1'b1);
    send(px(10, 0), 1'b0, 1'b1);
    drain();

    // Column wrap: 5th beat of a line reuses the last column word
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(win_exp(2, b, b == 0, 1'b0));
      exp_total++;
    end
    exp_q.push_back({1'b0, 1'b1, px(1, 3), px(2, 3), px(2, 4)});
    exp_total++;
    send_line(0, 4, 1'b1);
    send_line(1, 4, 1'b0);
    send_line(2, 5, 1'b0);
    drain();

`ifdef LINE_LEN_CHECK_EN
    // Short line 1 flags line_err until the next tuser beat
    send_line(0, 4, 1'b1);
    chk("len_err_clear", 128'(line_err), 128'd0);
    send_line(1, 3, 1'b0);
    chk("len_err_set", 128'(line_err), 128'd1);
    exp_q.push_back(win_exp(2, 0, 1'b1, 1'b0));
    exp_total++;
    send(px(2, 0), 1'b0, 1'b0);
    chk("len_err_sticky", 128'(line_err), 128'd1);
    send(px(3, 0), 1'b1, 1'b1);
    chk("len_err_tuser_clear", 128'(line_err), 128'd0);
    drain();
`endif

    // Reset mid-stream with a beat waiting in the output register
    m_tready = 1'b0;
    send_line(0, 4, 1'b1);
    send_line(1, 4, 1'b0);
    send(px(2, 0), 1'b0, 1'b0);
    @(negedge aclk);
    chk("pre_rst_m_tvalid", 128'(m_tvalid), 128'd1);
    chk("pre_rst_m_tuser",  128'(m_tuser),  128'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", 128'(m_tvalid), 128'd0);
    chk("mid_rst_m_tdata",  128'(m_tdata),  128'd0);
    chk("mid_rst_m_tuser",  128'(m_tuser),  128'd0);
    chk("mid_rst_m_tlast",  128'(m_tlast),  128'd0);
    chk("mid_rst_state",    128'(dbg_state), 128'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("post_rst_s_tready", 128'(s_tready), 128'd1);
    m_tready = 1'b1;
    send_line(14, 4, 1'b0);
    exp_line(6, 4, 1'b1);
    send_line(4, 4, 1'b1);
    send_line(5, 4, 1'b0);
    send_line(6, 4, 1'b0);
    drain();

    chk("total_count", 128'(recv_cnt), 128'(exp_total));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
